// File: rtl/fc_pkg.sv
// Shared definitions for the fully connected layer: default word format,
// FSM state encodings and the signed saturation helper.
package fc_pkg;

  localparam int unsigned FC_WL_DEF   = 16;
  localparam int unsigned FC_FRAC_DEF = 8;
  // Working width of the saturation helper; covers any accumulator this block builds.
  localparam int unsigned SAT_W       = 128;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} main_state_e;
  typedef enum logic [1:0] {B_IDLE, B_LOAD, B_READY} bias_state_e;

  // Clamp a signed value to the range of a wl-bit signed word.
  function automatic logic signed [SAT_W-1:0] fc_sat(input logic signed [SAT_W-1:0] x,
                                                    input int unsigned wl);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (wl - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (x > hi)      fc_sat = hi;
    else if (x < lo) fc_sat = lo;
    else             fc_sat = x;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron: VEC_WORDS signed products per beat, summed and added to a
// wide accumulator seeded with the bias; result is floor-shifted by FRAC,
// saturated to WL bits (ReLU applied when FC_RELU_EN is defined) and held.
// Ports: clk, rst (sync, active-low), vld_i (beat data present), first_i (first
// beat, seed with bias), load_i (capture result), x_i/w_i beat words, bias_i, y_o.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int unsigned VEC_WORDS = 8,
  parameter int unsigned BEATS     = 48,
  parameter int unsigned WL        = FC_WL_DEF,
  parameter int unsigned FRAC      = FC_FRAC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld_i,
  input  logic                    first_i,
  input  logic                    load_i,
  input  logic [VEC_WORDS*WL-1:0] x_i,
  input  logic [VEC_WORDS*WL-1:0] w_i,
  input  logic [WL-1:0]           bias_i,
  output logic [WL-1:0]           y_o
);

  localparam int unsigned PW    = 2 * WL;
  localparam int unsigned SUM_W = PW + $clog2(VEC_WORDS) + 1;
  localparam int unsigned ACC_W = PW + $clog2(BEATS * VEC_WORDS) + 1;

  logic signed [SUM_W-1:0] sum_c;
  logic signed [ACC_W-1:0] acc_q, acc_d, bias_ext_c, shifted_c;
  logic [WL-1:0]           res_c, y_d, y_q;

  // Full-precision products of one beat, summed.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(VEC_WORDS); i++) begin
      sum_c = sum_c + SUM_W'(PW'($signed(x_i[i*WL +: WL])) * PW'($signed(w_i[i*WL +: WL])));
    end
  end

  assign bias_ext_c = ACC_W'($signed(bias_i)) <<< FRAC;

  // First beat replaces the previous inference's total with the aligned bias.
  always_comb begin
    acc_d = acc_q;
    if (vld_i) acc_d = (first_i ? bias_ext_c : acc_q) + ACC_W'(sum_c);
  end

  assign shifted_c = acc_q >>> FRAC;
  assign res_c     = WL'(fc_sat(SAT_W'(shifted_c), WL));

`ifdef FC_RELU_EN
  assign y_d = res_c[WL-1] ? '0 : res_c;
`else
  assign y_d = res_c;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      if (load_i) y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/fc_layer_param.sv
// Parameterised fully connected layer. A bias FSM fetches OUT_CH bias words;
// a main FSM streams BEATS input/weight beats into OUT_CH MAC lanes and pulses
// output_valid BEATS+3 cycles after a start is accepted. Memories have a
// one-cycle read latency. Optional macro FC_RELU_EN clamps negative results to 0.
// Ports: clk, rst (sync, active-low), start, bias_store_done, input_data,
// weight_data, bias_data, read_{data,weight,bias}_{addr,signal}, busy,
// bias_ready, output_valid, output_data (channel 0 in LSBs).
module fc_layer_param
  import fc_pkg::*;
#(
  parameter int unsigned OUT_CH    = 10,
  parameter int unsigned VEC_WORDS = 8,
  parameter int unsigned BEATS     = 48,
  parameter int unsigned WL        = FC_WL_DEF,
  parameter int unsigned FRAC      = FC_FRAC_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           bias_store_done,
  input  logic [VEC_WORDS*WL-1:0]        input_data,
  input  logic [OUT_CH*VEC_WORDS*WL-1:0] weight_data,
  input  logic [WL-1:0]                  bias_data,
  output logic [15:0]                    read_data_addr,
  output logic [15:0]                    read_weight_addr,
  output logic [15:0]                    read_bias_addr,
  output logic                           read_data_signal,
  output logic                           read_weight_signal,
  output logic                           read_bias_signal,
  output logic                           busy,
  output logic                           bias_ready,
  output logic                           output_valid,
  output logic [OUT_CH*WL-1:0]           output_data
);

  localparam int unsigned AW     = 16;
  localparam int unsigned LANE_W = VEC_WORDS * WL;

  main_state_e   state_q, state_d;
  bias_state_e   bstate_q, bstate_d;
  logic [AW-1:0] beat_q, beat_d, bcnt_q, bcnt_d;
  logic          drain_q, drain_d;
  logic          accept_c, load_c;
  logic          rd_sig_q, dvld_q, first_q, rb_sig_q, bvld_q;
  logic          busy_q, bready_q, ovld_q;
  logic [WL-1:0] bias_q [OUT_CH];

  assign accept_c = (state_q == IDLE) && start && bready_q;
  assign load_c   = (state_d == DONE);

  // Main FSM: RUN issues one beat address per cycle, DRAIN covers read
  // latency plus the final accumulate, DONE presents the result.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE:  if (accept_c) state_d = RUN;
      RUN: begin
        beat_d = beat_q + AW'(1);
        if (beat_q == AW'(BEATS - 1)) begin
          state_d = DRAIN;
          beat_d  = '0;
        end
      end
      DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bias FSM: reload only while the main FSM is idle and not starting.
  always_comb begin
    bstate_d = bstate_q;
    bcnt_d   = bcnt_q;
    unique case (bstate_q)
      B_IDLE, B_READY: begin
        if (bias_store_done && (state_q == IDLE) && !accept_c) bstate_d = B_LOAD;
      end
      B_LOAD: begin
        bcnt_d = bcnt_q + AW'(1);
        if (bcnt_q == AW'(OUT_CH - 1)) begin
          bstate_d = B_READY;
          bcnt_d   = '0;
        end
      end
      default: bstate_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      bstate_q <= B_IDLE;
      beat_q   <= '0;
      bcnt_q   <= '0;
      drain_q  <= 1'b0;
      rd_sig_q <= 1'b0;
      dvld_q   <= 1'b0;
      first_q  <= 1'b0;
      rb_sig_q <= 1'b0;
      bvld_q   <= 1'b0;
      busy_q   <= 1'b0;
      bready_q <= 1'b0;
      ovld_q   <= 1'b0;
      for (int k = 0; k < int'(OUT_CH); k++) bias_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      bstate_q <= bstate_d;
      beat_q   <= beat_d;
      bcnt_q   <= bcnt_d;
      drain_q  <= drain_d;
      rd_sig_q <= (state_d == RUN);
      dvld_q   <= rd_sig_q;
      // Data for beat 0 arrives one cycle after its address.
      first_q  <= (state_q == RUN) && (beat_q == '0);
      rb_sig_q <= (bstate_d == B_LOAD);
      bvld_q   <= rb_sig_q;
      busy_q   <= (state_d != IDLE);
      bready_q <= (bstate_d == B_READY);
      ovld_q   <= (state_d == DONE);
      // Shift in from the top so the word at address k settles in bias_q[k].
      if (bvld_q) begin
        for (int k = 0; k < int'(OUT_CH) - 1; k++) bias_q[k] <= bias_q[k+1];
        bias_q[OUT_CH-1] <= bias_data;
      end
    end
  end

  for (genvar c = 0; c < OUT_CH; c++) begin : g_lane
    fc_mac_lane #(
      .VEC_WORDS(VEC_WORDS),
      .BEATS    (BEATS),
      .WL       (WL),
      .FRAC     (FRAC)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (dvld_q),
      .first_i(first_q),
      .load_i (load_c),
      .x_i    (input_data),
      .w_i    (weight_data[c*LANE_W +: LANE_W]),
      .bias_i (bias_q[c]),
      .y_o    (output_data[c*WL +: WL])
    );
  end

  assign read_data_addr     = beat_q;
  assign read_weight_addr   = beat_q;
  assign read_bias_addr     = bcnt_q;
  assign read_data_signal   = rd_sig_q;
  assign read_weight_signal = rd_sig_q;
  assign read_bias_signal   = rb_sig_q;
  assign busy               = busy_q;
  assign bias_ready         = bready_q;
  assign output_valid       = ovld_q;

endmodule

// File: tb/tb_fc_layer_param.sv
`timescale 1ns/1ps
module tb_fc_layer_param;

  localparam int unsigned OC = 10;
  localparam int unsigned VW = 8;
  localparam int unsigned NB = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, bsd;
  logic [VW*16-1:0]    input_data;
  logic [OC*VW*16-1:0] weight_data;
  logic [15:0]         bias_data;
  logic [15:0]         rda, rwa, rba;
  logic                rds, rws, rbs, busy, bias_ready, output_valid;
  logic [OC*16-1:0]    output_data;

  logic start2, bsd2;
  logic [15:0] in2, w2, b2, rda2, rwa2, rba2, out2;
  logic        rds2, rws2, rbs2, busy2, bready2, ovld2;

  fc_layer_param dut (
    .clk(clk), .rst(rst), .start(start), .bias_store_done(bsd),
    .input_data(input_data), .weight_data(weight_data), .bias_data(bias_data),
    .read_data_addr(rda), .read_weight_addr(rwa), .read_bias_addr(rba),
    .read_data_signal(rds), .read_weight_signal(rws), .read_bias_signal(rbs),
    .busy(busy), .bias_ready(bias_ready), .output_valid(output_valid),
    .output_data(output_data)
  );

  fc_layer_param #(.OUT_CH(1), .VEC_WORDS(1), .BEATS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bias_store_done(bsd2),
    .input_data(in2), .weight_data(w2), .bias_data(b2),
    .read_data_addr(rda2), .read_weight_addr(rwa2), .read_bias_addr(rba2),
    .read_data_signal(rds2), .read_weight_signal(rws2), .read_bias_signal(rbs2),
    .busy(busy2), .bias_ready(bready2), .output_valid(ovld2),
    .output_data(out2)
  );

  // Memory models: address seen in cycle n returns data during cycle n+1.
  logic [15:0] in_word = '0, w_word = '0;
  logic        pd = 1'b0, pw = 1'b0, pb = 1'b0;
  logic [15:0] pba = '0;
  always @(negedge clk) begin
    input_data  = pd ? {VW{in_word}} : {VW{16'h5A5A}};
    weight_data = pw ? {OC*VW{w_word}} : {OC*VW{16'hA5A5}};
    bias_data   = pb ? 16'(pba * 16'h0100) : 16'h5A5A;
    pd = rds; pw = rws; pb = rbs; pba = rba;
  end

  logic [15:0] in2_mem [2];
  logic [15:0] w2_mem [2];
  logic [15:0] b2_val = '0;
  logic        pd2 = 1'b0, pw2 = 1'b0, pb2 = 1'b0;
  logic [15:0] pda2 = '0, pwa2 = '0;
  always @(negedge clk) begin
    in2 = pd2 ? in2_mem[pda2[0]] : 16'h5A5A;
    w2  = pw2 ? w2_mem[pwa2[0]] : 16'hA5A5;
    b2  = pb2 ? b2_val : 16'h5A5A;
    pd2 = rds2; pw2 = rws2; pb2 = rbs2; pda2 = rda2; pwa2 = rwa2;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] relu_f(input logic [15:0] v);
`ifdef FC_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  // Reference for the single-lane instance.
  function automatic logic [15:0] ref2();
    longint acc;
    acc = longint'($signed(b2_val)) * 256;
    for (int i = 0; i < 2; i++) acc += longint'($signed(in2_mem[i])) * longint'($signed(w2_mem[i]));
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return relu_f(acc[15:0]);
  endfunction

  typedef struct {
    logic [15:0] x;
    logic [15:0] w;
    logic [15:0] base;
    logic [15:0] step;
  } vec_t;
  vec_t vecs [5];

  task automatic fetch_bias();
    bsd = 1'b1; @(negedge clk); bsd = 1'b0;
    for (int k = 0; k < int'(OC); k++) begin
      check($sformatf("bias rd cycle %0d {strobe,addr,ready}", k), {rbs, rba, bias_ready}, {1'b1, 16'(k), 1'b0});
      @(negedge clk);
    end
    check("bias_ready after fetch", bias_ready, 1);
    check("bias strobe off after fetch", rbs, 0);
  endtask

  task automatic fetch_bias2();
    bsd2 = 1'b1; @(negedge clk); bsd2 = 1'b0;
    check("small bias rd {strobe,addr}", {rbs2, rba2}, {1'b1, 16'd0});
    @(negedge clk);
    check("small bias_ready", bready2, 1);
  endtask

  task automatic run_main(input int id, input logic [15:0] base, input logic [15:0] step,
                          input bit start_in_done);
    int cyc; bit seen; int busy_lo; logic [15:0] e;
    start = 1'b1; @(negedge clk); start = 1'b0;
    cyc = 1; seen = 1'b0; busy_lo = 0;
    while (!seen && cyc < 200) begin
      if (output_valid === 1'b1) seen = 1'b1;
      else begin
        if (busy !== 1'b1) busy_lo++;
        @(negedge clk); cyc++;
      end
    end
    check($sformatf("v%0d output_valid latency", id), cyc, NB + 3);
    check($sformatf("v%0d busy low during run", id), busy_lo, 0);
    check($sformatf("v%0d busy at valid", id), busy, 1);
    for (int k = 0; k < int'(OC); k++) begin
      e = relu_f(16'(base + 16'(k) * step));
      check($sformatf("v%0d ch%0d", id, k), output_data[k*16 +: 16], e);
    end
    if (start_in_done) start = 1'b1;
    @(negedge clk); start = 1'b0;
    check($sformatf("v%0d valid single cycle", id), output_valid, 0);
    check($sformatf("v%0d busy after done", id), busy, 0);
    @(negedge clk);
    check($sformatf("v%0d idle after done", id), busy, 0);
  endtask

  task automatic run_small(input int id, input logic [15:0] hand);
    int cyc; bit seen;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 50) begin
      if (ovld2 === 1'b1) seen = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    check($sformatf("small%0d latency", id), cyc, 5);
    check($sformatf("small%0d vs model", id), out2, ref2());
    check($sformatf("small%0d vs hand value", id), out2, relu_f(hand));
    @(negedge clk);
    check($sformatf("small%0d valid single cycle", id), ovld2, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vcnt, bcnt, rcnt, first_v;

  initial begin
    vecs[0] = '{16'h0080, 16'h0040, 16'h3000, 16'h0100};
    vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000};
    vecs[2] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0000};
    vecs[3] = '{16'h0001, 16'hFFFF, 16'hFFFE, 16'h0100};
    vecs[4] = '{16'h0000, 16'h1234, 16'h0000, 16'h0100};

    rst = 1'b0; start = 1'b0; bsd = 1'b0; start2 = 1'b0; bsd2 = 1'b0;
    in2_mem[0] = '0; in2_mem[1] = '0; w2_mem[0] = '0; w2_mem[1] = '0;
    repeat (3) @(negedge clk);
    check("reset output_data zero", |output_data, 0);
    check("reset {busy,bias_ready,valid}", {busy, bias_ready, output_valid}, 0);
    check("reset strobes", {rds, rws, rbs}, 0);
    rst = 1'b1;
    @(negedge clk);

    // start before any bias fetch must be dropped
    start = 1'b1; @(negedge clk); start = 1'b0;
    vcnt = 0; bcnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (output_valid) vcnt++;
      if (busy) bcnt++;
      @(negedge clk);
    end
    check("start w/o bias: valid count", vcnt, 0);
    check("start w/o bias: busy cycles", bcnt, 0);

    fetch_bias();

    for (int i = 0; i < 5; i++) begin
      in_word = vecs[i].x;
      w_word  = vecs[i].w;
      run_main(i, vecs[i].base, vecs[i].step, i == 1);
    end

    // start and bias_store_done while busy are both dropped
    start = 1'b1; @(negedge clk); start = 1'b0;
    vcnt = 0; rcnt = 0; first_v = -1;
    for (int c = 1; c <= 130; c++) begin
      if (output_valid) begin
        vcnt++;
        if (first_v < 0) first_v = c;
      end
      if (rbs) rcnt++;
      start = (c == 10);
      bsd   = (c == 10);
      @(negedge clk);
    end
    start = 1'b0; bsd = 1'b0;
    check("busy starts: valid count", vcnt, 1);
    check("busy starts: first valid cycle", first_v, NB + 3);
    check("bias reload while busy ignored", rcnt, 0);
    check("bias_ready kept", bias_ready, 1);

    // reset for two cycles mid-RUN
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-run reset output_data zero", |output_data, 0);
    check("mid-run reset {busy,bias_ready,valid}", {busy, bias_ready, output_valid}, 0);
    check("mid-run reset strobes", {rds, rws, rbs}, 0);
    rst = 1'b1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    vcnt = 0; bcnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (output_valid) vcnt++;
      if (busy) bcnt++;
      @(negedge clk);
    end
    check("after abort: valid count", vcnt, 0);
    check("after abort: start needs bias", bcnt, 0);
    fetch_bias();
    in_word = vecs[0].x; w_word = vecs[0].w;
    run_main(5, vecs[0].base, vecs[0].step, 1'b0);

    // single-lane, two-beat instance with distinct per-beat data
    b2_val = 16'hFF80;
    in2_mem[0] = 16'h0180; w2_mem[0] = 16'h0200;
    in2_mem[1] = 16'hFF00; w2_mem[1] = 16'h0100;
    fetch_bias2();
    run_small(0, 16'h0180);

    b2_val = 16'h7FFF;
    in2_mem[0] = 16'h7FFF; w2_mem[0] = 16'h7FFF;
    in2_mem[1] = 16'h7FFF; w2_mem[1] = 16'h7FFF;
    fetch_bias2();
    run_small(1, 16'h7FFF);

    b2_val = 16'h8000;
    in2_mem[0] = 16'h8000; w2_mem[0] = 16'h7FFF;
    in2_mem[1] = 16'h8000; w2_mem[1] = 16'h7FFF;
    fetch_bias2();
    run_small(2, 16'h8000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc_layer_param.md
FC_LAYER_PARAM -- requirements
Module: fc_layer_param

Interface
REQ-001 SHALL have parameter OUT_CH, default 10, number of output neurons (1..32).
REQ-002 SHALL have parameter VEC_WORDS, default 8, input words consumed per beat.
REQ-003 SHALL have parameter BEATS, default 48, beats per input vector (2..65535).
REQ-004 SHALL have parameter WL, default 16, signed fixed-point word width.
REQ-005 SHALL have parameter FRAC, default 8, fractional bits (Q(WL-FRAC).FRAC).
REQ-006 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-008 SHALL have ports: start  in  1  pixel vector stored; request one inference.
REQ-009 SHALL have ports: bias_store_done  in  1  bias memory loaded; request bias fetch.
REQ-010 SHALL have ports: input_data  in  VEC_WORDS*WL  input beat, word 0 in LSBs.
REQ-011 SHALL have ports: weight_data  in  OUT_CH*VEC_WORDS*WL  weights for all channels, channel 0 in LSBs.
REQ-012 SHALL have ports: bias_data  in  WL  one bias word.
REQ-013 SHALL have ports: read_data_addr / read_weight_addr / read_bias_addr  out  16 each  memory addresses.
REQ-014 SHALL have ports: read_data_signal / read_weight_signal / read_bias_signal  out  1 each  read strobes.
REQ-015 SHALL have ports: busy  out  1; bias_ready  out  1; output_valid  out  1; output_data  out  OUT_CH*WL  channel 0 in LSBs.

Function
REQ-016 All memories SHALL be treated as 1-cycle read latency: data for address issued in cycle n is sampled in cycle n+1.
REQ-017 Bias FSM SHALL have states B_IDLE, B_LOAD, B_READY; bias_store_done in B_IDLE or B_READY (main FSM IDLE) enters B_LOAD, otherwise ignored.
REQ-018 B_LOAD SHALL assert read_bias_signal for OUT_CH cycles, addr 0..OUT_CH-1, shift returned words so bias[k] = word at addr k, then enter B_READY; bias_ready = (state==B_READY).
REQ-019 Main FSM SHALL have states IDLE, RUN, DRAIN, DONE; start accepted only in IDLE with bias_ready=1, otherwise ignored (no queuing).
REQ-020 RUN SHALL last BEATS cycles, asserting read_data_signal and read_weight_signal, read_data_addr = read_weight_addr = 0..BEATS-1, one per cycle.
REQ-021 Each channel c SHALL compute acc = (bias[c] << FRAC) + sum over beats and words of (x*w) with products full 2*WL signed, accumulator 2*WL+ceil(log2(BEATS*VEC_WORDS))+1 bits, never overflowing.
REQ-022 Result SHALL be acc >>> FRAC (arithmetic, floor), then saturated to [-2^(WL-1), 2^(WL-1)-1].
REQ-023 output_valid SHALL pulse exactly 1 cycle, BEATS+3 cycles after the start-accept cycle; output_data updates in that cycle and holds until the next pulse.
REQ-024 busy SHALL be 1 from the cycle after start-accept until the cycle output_valid is high, inclusive.
REQ-025 start asserted in the DONE cycle SHALL be ignored; earliest next accept is the cycle after DONE.
REQ-026 Bias reload SHALL NOT be started while busy=1; bias_store_done then is dropped.

Reset
REQ-027 rst=0 at a clock edge SHALL force both FSMs to idle, all counters, accumulators, biases and output_data to 0, all strobes, busy, bias_ready, output_valid to 0.
REQ-028 Reset mid-RUN SHALL abort with no output_valid; biases SHALL be refetched before the next accept.

Configuration
REQ-029 Macro FC_RELU_EN defined: each saturated result < 0 SHALL be replaced by 0; undefined: signed saturated result output unchanged; latency identical in both.

Structure
REQ-030 Package fc_pkg SHALL hold WL/FRAC defaults, FSM state enums and the saturation function.
REQ-031 Sub-module fc_mac_lane (one channel: products, adder tree, accumulator, shift, saturate, optional ReLU) SHALL be instantiated OUT_CH times via generate.

Verification
REQ-032 Reset: rst=0 two cycles mid-RUN -> all outputs 0, no output_valid, bias_ready 0.
REQ-033 Bias fetch: bias_store_done pulse, biases k*0x0100 at addr k -> read_bias_addr 0..9 over 10 cycles, bias_ready rises next cycle.
REQ-034 Defaults, inputs 0x0080, weights 0x0040, biases as above -> output_valid at start+51, channel k = 0x3000+k*0x0100.
REQ-035 Saturation: inputs 0x7FFF, weights 0x7FFF -> all 0x7FFF; weights 0x8000 -> 0x8000 (0x0000 with FC_RELU_EN).
REQ-036 start before bias_ready and start while busy -> ignored, exactly one output_valid per accepted start.
REQ-037 Parameter sweep OUT_CH=1, VEC_WORDS=1, BEATS=2 -> latency 5 cycles, result matches reference model.
